instr_encode: RTL

Instruction encoder and sequencer: the inverse of the instruction decoder. It accepts a format tag and instruction fields over a valid/ready request channel, packs them into a 32-bit RV32I word, checks that the immediate is encodable, and tags each word with a sequential instruction-memory address. Results are buffered in a small FIFO and presented on a valid/ready output channel. It sits between test/boot-loader logic and the instruction-memory write port.

---
 rtl/instr_encode.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_encode.sv
// instr_encode: packs RV32I instruction fields into 32-bit words, flags
// immediates that the chosen format cannot represent, tags each word with a
// sequential instruction-memory address and buffers the results in a small
// FIFO that drains over a valid/ready output channel.
module instr_encode #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  // request channel
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0]               req_fmt_i,
  input  logic [6:0]               req_op_i,
  input  logic [4:0]               req_rd_i,
  input  logic [4:0]               req_rs1_i,
  input  logic [4:0]               req_rs2_i,
  input  logic [2:0]               req_funct3_i,
  input  logic [6:0]               req_funct7_i,
  input  logic [31:0]              req_imm_i,
  // output channel
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_instr_o,
  output logic [31:0]              out_addr_o,
  output logic                     out_err_o,
  // status
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [7:0]               err_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [LW-1:0] lvl_t;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  fmt_e        fmt;
  logic [31:0] enc_word;
  logic        enc_err;

  // An immediate fits an N-bit signed field when every bit from the field's
  // sign position upward carries the same value.
  logic imm_fits_12;   // I/S: imm[31:11] uniform
  logic imm_fits_13;   // B:   imm[31:12] uniform
  logic imm_fits_21;   // J:   imm[31:20] uniform

  assign fmt         = fmt_e'(req_fmt_i);
  assign imm_fits_12 = (&req_imm_i[31:11]) | ~(|req_imm_i[31:11]);
  assign imm_fits_13 = (&req_imm_i[31:12]) | ~(|req_imm_i[31:12]);
  assign imm_fits_21 = (&req_imm_i[31:20]) | ~(|req_imm_i[31:20]);

  // Pack the request fields by format and flag unrepresentable immediates.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value held and no latch is inferred.
    enc_word = 32'h0;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_word = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i,
                    req_rd_i, req_op_i};
      end
      FMT_I: begin
        enc_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i,
                    req_op_i};
        enc_err  = ~imm_fits_12;
      end
      FMT_S: begin
        enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                    req_imm_i[4:0], req_op_i};
        enc_err  = ~imm_fits_12;
      end
      FMT_B: begin
        enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i,
                    req_funct3_i, req_imm_i[4:1], req_imm_i[11], req_op_i};
        enc_err  = req_imm_i[0] | ~imm_fits_13;
      end
      FMT_U: begin
        enc_word = {req_imm_i[31:12], req_rd_i, req_op_i};
        enc_err  = |req_imm_i[11:0];
      end
      FMT_J: begin
        enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11],
                    req_imm_i[19:12], req_rd_i, req_op_i};
        enc_err  = req_imm_i[0] | ~imm_fits_21;
      end
      default: begin
        // Format codes 6 and 7 have no encoding: emit a zero word, flagged.
        enc_word = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer state and output FIFO
  // ---------------------------------------------------------------------------
  entry_t      mem_q [DEPTH];
  ptr_t        wr_ptr_q,  wr_ptr_d;
  ptr_t        rd_ptr_q,  rd_ptr_d;
  lvl_t        level_q,   level_d;
  logic [31:0] addr_q,    addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head;

  assign fifo_full  = (level_q == lvl_t'(DEPTH));
  assign fifo_empty = (level_q == '0);

  // Ready looks only at registered occupancy and flush; a pop in the same
  // cycle never frees room for a push into a full FIFO.
  assign req_ready_o = ~fifo_full & ~flush_i;
  assign push        = req_valid_i & req_ready_o;
  assign pop         = ~fifo_empty & out_ready_i & ~flush_i;

  assign push_entry = '{addr: addr_q, instr: enc_word, err: enc_err};

  // Next-state: flush wins over push and pop; error count survives a flush.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      addr_d   = BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
        addr_d   = addr_q + 32'd4;
        if (enc_err && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + lvl_t'(1);
        2'b01:   level_d = level_q - lvl_t'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control registers: pointers, occupancy, address tag and error counter.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is assigned with non-blocking '<=' so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      addr_q    <= BASE_ADDR;
      err_cnt_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // FIFO storage: written on push only.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy is, and
    // the output gating below keeps stale contents from ever being visible.
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head = mem_q[rd_ptr_q];

  assign out_valid_o = ~fifo_empty;
  assign out_instr_o = fifo_empty ? 32'h0 : head.instr;
  assign out_addr_o  = fifo_empty ? 32'h0 : head.addr;
  assign out_err_o   = fifo_empty ? 1'b0  : head.err;
  assign level_o     = level_q;
  assign err_count_o = err_cnt_q;

endmodule
